// File: rtl/key_scan_ctrl.sv
// rtl/key_scan_ctrl.sv - 4x4 active-low keypad scanner with debounce and valid/ready key output
module key_scan_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int CNT_W      = 16,
  parameter int DEBOUNCE_N = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overflow
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DB_N     = 4'(DEBOUNCE_N);

  logic [3:0]       col_meta;
  logic [3:0]       col_s;
  logic [CNT_W-1:0] presc;
  logic             tick;
  state_t           state, state_n;
  logic [1:0]       row, row_n;
  logic [3:0]       cand, cand_n;
  logic [3:0]       stable, stable_n;
  logic [3:0]       rel, rel_n;
  logic             hit;
  logic [1:0]       col;
  logic [3:0]       code_now;
  logic             confirm;

  // col_in is asynchronous; idle (all high) is the safe reset value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc <= '0;
    else if (presc == DIV_LAST) presc <= '0;
    else presc <= presc + 1'b1;
  end

  assign tick = (presc == DIV_LAST);
  assign hit  = (col_s != 4'hF);

  always_comb begin
    col = 2'd0;
    if (!col_s[0]) col = 2'd0;
    else if (!col_s[1]) col = 2'd1;
    else if (!col_s[2]) col = 2'd2;
    else if (!col_s[3]) col = 2'd3;
  end

  assign code_now = {row, col};

  always_comb begin
    state_n  = state;
    row_n    = row;
    cand_n   = cand;
    stable_n = stable;
    rel_n    = rel;
    confirm  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit) begin
            cand_n   = code_now;
            stable_n = 4'd1;
            if (DB_N == 4'd1) begin
              confirm = 1'b1;
              state_n = RELEASE;
              rel_n   = 4'd0;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            row_n = row + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (hit && code_now == cand) begin
            stable_n = stable + 4'd1;
            if (stable + 4'd1 == DB_N) begin
              confirm = 1'b1;
              state_n = RELEASE;
              rel_n   = 4'd0;
            end
          end else begin
            state_n  = SCAN;
            row_n    = row + 2'd1;
            stable_n = 4'd0;
          end
        end
        RELEASE: begin
          if (!hit) begin
            rel_n = rel + 4'd1;
            if (rel + 4'd1 == DB_N) begin
              state_n = SCAN;
              row_n   = row + 2'd1;
              rel_n   = 4'd0;
            end
          end else begin
            rel_n = 4'd0;
          end
        end
        default: begin
          state_n = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SCAN;
      row     <= 2'd0;
      cand    <= 4'd0;
      stable  <= 4'd0;
      rel     <= 4'd0;
      row_out <= 4'b1110;
      key_down <= 1'b0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      cand     <= cand_n;
      stable   <= stable_n;
      rel      <= rel_n;
      row_out  <= ~(4'b0001 << row_n);
      key_down <= (state_n == RELEASE);
    end
  end

  // A confirm may reuse the slot being accepted this cycle; otherwise the new key is lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (confirm) begin
        if (!key_valid || key_ready) begin
          key_valid <= 1'b1;
          key_code  <= cand_n;
        end else begin
          overflow <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb/tb_key_scan_ctrl.sv - bench for key_scan_ctrl with a keypad model and a tick-level reference
module tb_key_scan_ctrl;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b1;
  logic        key_down;
  logic        overflow;
  logic [15:0] pressed = '0;

  int errors = 0;
  int checks = 0;
  int slot = 0;
  int m_row, m_mode, m_cnt, m_cand, m_code;
  bit m_kv, m_ovf;
  int ovf_seen = 0;
  int accepted[$];
  int guard;

  key_scan_ctrl #(.SCAN_DIV(4), .CNT_W(16), .DEBOUNCE_N(N)) dut (
    .clk(clk), .reset(reset), .col_in(col_in), .row_out(row_out),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_down(key_down), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bound_check(input string tag, input int g);
    checks++;
    assert (g < 64) else begin
      errors++;
      $error("FAIL %s timeout got=%0d limit=64", tag, g);
    end
  endtask

  function automatic int scan_col();
    for (int c = 0; c < 4; c++)
      if (pressed[m_row*4+c]) return c;
    return -1;
  endfunction

  task automatic model_reset();
    m_row = 0; m_mode = 0; m_cnt = 0; m_cand = 0; m_code = 0; m_kv = 0; m_ovf = 0;
  endtask

  // Reference: modes 0 scanning, 1 confirming a candidate, 2 waiting for release
  task automatic model_edge();
    bit confirm;
    int c;
    confirm = 0;
    m_ovf = 0;
    if (m_kv && key_ready) accepted.push_back(m_code);
    if (slot == 3) begin
      c = scan_col();
      case (m_mode)
        0: if (c >= 0) begin m_cand = m_row*4 + c; m_cnt = 1; m_mode = 1; end
           else m_row = (m_row + 1) % 4;
        1: if (c >= 0 && m_row*4 + c == m_cand) begin
             m_cnt++;
             if (m_cnt == N) begin confirm = 1; m_mode = 2; m_cnt = 0; end
           end else begin m_mode = 0; m_cnt = 0; m_row = (m_row + 1) % 4; end
        default: if (c < 0) begin
             m_cnt++;
             if (m_cnt == N) begin m_mode = 0; m_cnt = 0; m_row = (m_row + 1) % 4; end
           end else m_cnt = 0;
      endcase
    end
    if (confirm) begin
      if (!m_kv || key_ready) begin m_kv = 1; m_code = m_cand; end
      else m_ovf = 1;
    end else if (m_kv && key_ready) m_kv = 0;
  endtask

  task automatic cycle();
    logic [3:0] er;
    model_edge();
    @(posedge clk);
    #1;
    slot = (slot + 1) % 4;
    er = 4'b0001 << m_row;
    check("row_out", row_out, ~er);
    check("key_valid", {3'b0, key_valid}, {3'b0, m_kv});
    check("key_code", key_code, 4'(m_code));
    check("key_down", {3'b0, key_down}, {3'b0, m_mode == 2});
    check("overflow", {3'b0, overflow}, {3'b0, m_ovf});
    if (overflow === 1'b1) ovf_seen++;
  endtask

  task automatic run_ticks(input int n);
    repeat (n * 4) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_row_out", row_out, 4'b1110);
    check("rst_key_valid", {3'b0, key_valid}, 4'd0);
    check("rst_key_code", key_code, 4'd0);
    check("rst_key_down", {3'b0, key_down}, 4'd0);
    check("rst_overflow", {3'b0, overflow}, 4'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    slot = 0;
  endtask

  task automatic wait_mode(input string tag, input int mode);
    guard = 0;
    while (m_mode != mode && guard < 64) begin run_ticks(1); guard++; end
    bound_check(tag, guard);
  endtask

  initial begin
    #1;
    do_reset();

    // idle scan
    run_ticks(6);
    check("idle_valid", {3'b0, key_valid}, 4'd0);

    // row 2 col 1 held, then released
    accepted.delete();
    pressed = 16'h0200;
    wait_mode("wait_confirm9", 2);
    check("code9", key_code, 4'd9);
    check("valid9", {3'b0, key_valid}, 4'd1);
    check("row_frozen", row_out, 4'b1011);
    run_ticks(3);
    check("row_held", row_out, 4'b1011);
    pressed = '0;
    run_ticks(2);
    check("row_rel2", row_out, 4'b1011);
    run_ticks(1);
    check("row_after_rel", row_out, 4'b0111);
    check("down_after_rel", {3'b0, key_down}, 4'd0);
    check("one_code_cnt", 4'(accepted.size()), 4'd1);
    if (accepted.size() > 0) check("one_code_val", 4'(accepted[0]), 4'd9);

    // short press row 1 col 3
    accepted.delete();
    pressed = 16'h0080;
    wait_mode("wait_det7", 1);
    run_ticks(1);
    pressed = '0;
    run_ticks(1);
    check("row_resume2", row_out, 4'b1011);
    run_ticks(4);
    check("short_no_code", 4'(accepted.size()), 4'd0);

    // row 0, cols 0 and 2 together
    pressed = 16'h0005;
    wait_mode("wait_multi", 2);
    check("multi_code", key_code, 4'd0);
    pressed = '0;
    wait_mode("wait_multi_rel", 0);

    // consumer stalled: second key dropped
    key_ready = 1'b0;
    pressed = 16'h0020;
    wait_mode("wait_c5", 2);
    pressed = '0;
    wait_mode("wait_c5_rel", 0);
    ovf_seen = 0;
    pressed = 16'h1000;
    wait_mode("wait_c12", 2);
    check("ovf_once", 4'(ovf_seen), 4'd1);
    check("code_kept5", key_code, 4'd5);
    pressed = '0;
    key_ready = 1'b1;
    cycle();
    check("valid_drop", {3'b0, key_valid}, 4'd0);
    repeat (3) cycle();
    wait_mode("wait_c12_rel", 0);

    // confirm coinciding with accept
    key_ready = 1'b0;
    pressed = 16'h0008;
    wait_mode("wait_c3", 2);
    pressed = '0;
    wait_mode("wait_c3_rel", 0);
    pressed = 16'h0400;
    guard = 0;
    while (!(m_mode == 1 && m_cnt == N - 1) && guard < 64) begin run_ticks(1); guard++; end
    bound_check("wait_pre10", guard);
    ovf_seen = 0;
    repeat (3) cycle();
    key_ready = 1'b1;
    cycle();
    check("coin_valid", {3'b0, key_valid}, 4'd1);
    check("coin_code", key_code, 4'd10);
    check("coin_no_ovf", 4'(ovf_seen), 4'd0);
    pressed = '0;
    wait_mode("wait_c10_rel", 0);

    // reset while debouncing; held key must be debounced again
    pressed = 16'h0040;
    wait_mode("wait_det6", 1);
    cycle();
    cycle();
    do_reset();
    wait_mode("wait_c6", 2);
    check("code6", key_code, 4'd6);
    pressed = '0;
    wait_mode("wait_c6_rel", 0);

    // random presses and consumer back-pressure
    repeat (40) begin
      int hold;
      if ($urandom_range(0, 2) == 0) pressed = '0;
      else begin
        pressed = 16'(1) << $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0) pressed = pressed | (16'(1) << $urandom_range(0, 15));
      end
      hold = $urandom_range(1, 6);
      repeat (hold * 4) begin
        key_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
